// File: rtl/bit_symbol_packer.sv
// ---------------------------------------------------------------------------
// bit_symbol_packer
//   Collects a byte stream into one 16-phase symbol frame for the selected
//   modulation and presents the frame as per-phase I/Q bit groups to the
//   constellation mapper.
//
// Ports
//   clk         in   system clock
//   rst         in   asynchronous reset, active low
//   mod_index   in   00 BPSK, 01 QPSK, 10 QAM16, 11 QAM64 (latched on byte 0)
//   in_data     in   stream byte, MSB transmitted first
//   in_valid    in   in_data valid
//   in_ready    out  packer can accept a byte (state only)
//   bit_data_i  out  per-phase I bit groups, MSB-first, unused upper bits 0
//   bit_data_q  out  per-phase Q bit groups, MSB-first, unused upper bits 0
//   frame_mod   out  modulation the presented frame was built with
//   out_valid   out  frame present
//   out_ready   in   consumer takes the frame
// ---------------------------------------------------------------------------
module bit_symbol_packer #(
  parameter int PHASES = 16,
  parameter int BYTE_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               mod_index,
  input  logic [BYTE_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [0:PHASES-1][2:0]   bit_data_i,
  output logic [0:PHASES-1][2:0]   bit_data_q,
  output logic [1:0]               frame_mod,
  output logic                     out_valid,
  input  logic                     out_ready
);

  // Largest frame (QAM64): 16 phases x 6 bits = 96 bits = 12 bytes.
  localparam int ACC_W     = 96;
  localparam int MAX_BYTES = 12;

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  // Number of bytes that make up one frame for a modulation.
  function automatic logic [3:0] bytes_needed(input logic [1:0] mod);
    logic [3:0] n;
    case (mod)
      2'b00:   n = 4'd2;
      2'b01:   n = 4'd4;
      2'b10:   n = 4'd8;
      default: n = 4'd12;
    endcase
    return n;
  endfunction

  // Extract the I (is_q = 0) or Q (is_q = 1) group of phase k.
  // Stream bit n lives at acc[95-n], so shifting left by n brings it to
  // the top of the word and the group is read from the top bits.
  function automatic logic [2:0] extract_group(input logic [ACC_W-1:0] acc,
                                               input logic [1:0]       mod,
                                               input logic [3:0]       k,
                                               input logic             is_q);
    logic [6:0]       n;
    logic [ACC_W-1:0] sh;
    logic [2:0]       g;
    case (mod)
      2'b00:   n = {3'd0, k};                              // k
      2'b01:   n = {2'd0, k, is_q};                        // 2k + q
      2'b10:   n = {1'b0, k, is_q, 1'b0};                  // 4k + 2q
      default: n = (7'd6 * {3'd0, k}) + (is_q ? 7'd3 : 7'd0); // 6k + 3q
    endcase
    sh = acc << n;
    case (mod)
      2'b00:   g = is_q ? 3'd0 : {2'd0, sh[ACC_W-1]};
      2'b01:   g = {2'd0, sh[ACC_W-1]};
      2'b10:   g = {1'b0, sh[ACC_W-1 -: 2]};
      default: g = sh[ACC_W-1 -: 3];
    endcase
    return g;
  endfunction

  state_e                   state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [1:0]               lat_q, lat_d;
  logic [ACC_W-1:0]         acc_q, acc_d;
  logic [0:PHASES-1][2:0]   bdi_q, bdi_d;
  logic [0:PHASES-1][2:0]   bdq_q, bdq_d;
  logic [1:0]               fmod_q, fmod_d;
  logic                     ov_q, ov_d;

  logic                     xfer_s;
  logic                     slot_free_s;
  logic [1:0]               cur_mod_s;
  logic                     load_s;
  logic [ACC_W-1:0]         load_acc_s;
  logic [1:0]               load_mod_s;

  assign in_ready   = (state_q == ST_FILL);
  assign bit_data_i = bdi_q;
  assign bit_data_q = bdq_q;
  assign frame_mod  = fmod_q;
  assign out_valid  = ov_q;

  // Next-state, accumulator fill and output-slot load decision.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lat_d      = lat_q;
    acc_d      = acc_q;
    bdi_d      = bdi_q;
    bdq_d      = bdq_q;
    fmod_d     = fmod_q;
    ov_d       = ov_q;
    load_s     = 1'b0;
    load_acc_s = acc_q;
    load_mod_s = lat_q;

    xfer_s      = in_valid && (state_q == ST_FILL);
    slot_free_s = !ov_q || out_ready;
    // The frame's modulation comes straight from the input on byte 0.
    cur_mod_s   = (cnt_q == 4'd0) ? mod_index : lat_q;

    case (state_q)
      ST_FILL: begin
        if (xfer_s) begin
          for (int b = 0; b < MAX_BYTES; b++) begin
            if (cnt_q == 4'(b)) begin
              acc_d[7'(ACC_W - 1 - 8 * b) -: 8] = in_data;
            end else begin
              acc_d[7'(ACC_W - 1 - 8 * b) -: 8] = acc_q[7'(ACC_W - 1 - 8 * b) -: 8];
            end
          end
          lat_d = cur_mod_s;
          if (cnt_q == (bytes_needed(cur_mod_s) - 4'd1)) begin
            cnt_d = 4'd0;
            if (slot_free_s) begin
              // Built from acc_d so the byte accepted on this edge is included.
              load_s     = 1'b1;
              load_acc_s = acc_d;
              load_mod_s = cur_mod_s;
            end else begin
              state_d = ST_PEND;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_PEND: begin
        if (out_ready) begin
          load_s     = 1'b1;
          load_acc_s = acc_q;
          load_mod_s = lat_q;
          state_d    = ST_FILL;
        end else begin
          state_d = ST_PEND;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase

    if (load_s) begin
      ov_d   = 1'b1;
      fmod_d = load_mod_s;
      for (int k = 0; k < PHASES; k++) begin
        bdi_d[4'(k)] = extract_group(load_acc_s, load_mod_s, 4'(k), 1'b0);
        bdq_d[4'(k)] = extract_group(load_acc_s, load_mod_s, 4'(k), 1'b1);
      end
    end else if (ov_q && out_ready) begin
      // Frame taken and nothing new: drop valid, keep the data.
      ov_d = 1'b0;
    end else begin
      ov_d = ov_q;
    end
  end

  // State, accumulator and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_FILL;
      cnt_q   <= 4'd0;
      lat_q   <= 2'd0;
      acc_q   <= {ACC_W{1'b0}};
      bdi_q   <= '0;
      bdq_q   <= '0;
      fmod_q  <= 2'd0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      acc_q   <= acc_d;
      bdi_q   <= bdi_d;
      bdq_q   <= bdq_d;
      fmod_q  <= fmod_d;
      ov_q    <= ov_d;
    end
  end

endmodule
